game_countdown_timer: RTL and testbench
=======================================

Name: game_countdown_timer

Overview:
- Countdown timer that sits directly upstream of the game FSM and produces its `timer_expired` input.
- Divides the 100 MHz system clock into a 1 Hz seconds tick internally, so the design needs no second clock.
- Counts the round length down from a parameterised start value.
- Drives seconds-remaining in binary and 2-digit BCD to the seven-segment display path, plus a low-time warning for LEDs.

Parameters:
- CLK_HZ, 100_000_000, clkIn cycles per second tick; overridden to small values in simulation.
- GAME_SECONDS, 30, round length in seconds; legal range 1..99.
- WARN_SECONDS, 5, warning threshold in seconds; legal range 0..GAME_SECONDS.

Ports:
- clkIn  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- startGame  input  1  start/restart request, sampled every cycle.
- pause  input  1  freezes countdown; used only with PAUSE_EN (see Optional Feature).
- timer_running  output  1  high while counting down.
- sec_tick  output  1  one-cycle pulse on each elapsed second while running.
- timer_expired  output  1  one-cycle pulse when the count reaches 0.
- game_over  output  1  level, high from expiry until the next start or reset.
- secs_left  output  7  seconds remaining, binary.
- secs_tens  output  4  BCD tens digit of secs_left.
- secs_ones  output  4  BCD ones digit of secs_left.
- time_warning  output  1  high while running and 0 < secs_left <= WARN_SECONDS.

Behaviour:
- One clock domain: clkIn. Reset is synchronous and active-high; reset has priority over every other input.
- All outputs are registered. All outputs update on the same edge, so they are mutually consistent in every cycle.
- Reset values:
  - state = IDLE, prescaler = 0.
  - secs_left = GAME_SECONDS; secs_tens/secs_ones = its BCD digits.
  - timer_running, sec_tick, timer_expired, game_over, time_warning = 0.
- State machine states: IDLE, RUNNING, DONE.
- IDLE:
  - Outputs hold their reset values.
  - startGame=1 at edge N: state=RUNNING, secs_left=GAME_SECONDS, prescaler=0, timer_running=1 from edge N.
- RUNNING, prescaler:
  - Prescaler counts 0..CLK_HZ-1 and wraps to 0.
  - On the wrap edge: sec_tick=1 for one cycle and secs_left decrements by 1.
  - BCD decrement: ones 0 -> 9 with tens-1; otherwise ones-1.
  - The first sec_tick is high exactly CLK_HZ cycles after timer_running rises.
- RUNNING, expiry:
  - Applies on the wrap edge where secs_left==1.
  - At that edge: secs_left=0, sec_tick=1, timer_expired=1 (one cycle), state=DONE, timer_running=0, game_over=1.
- RUNNING, startGame: ignored; no restart, no count change.
- DONE:
  - secs_left is held at 0 and game_over=1.
  - startGame=1 behaves as in IDLE: reload, enter RUNNING, game_over=0 from the same edge.
- time_warning: registered and evaluated from the next-state values of state and secs_left.
- Invariant: secs_tens*10 + secs_ones == secs_left in every cycle. secs_left never underflows.
- Reset mid-run: next cycle is in IDLE with reset values. No timer_expired pulse is produced.
- Reset and startGame together: reset wins; the block stays in IDLE.

Optional Feature:
- Macro: GAME_TIMER_PAUSE_EN.
- Defined:
  - While state=RUNNING and pause=1, the prescaler and secs_left freeze and no sec_tick is produced.
  - timer_running stays 1 and time_warning holds its value.
  - Counting resumes from the frozen prescaler value when pause returns to 0.
  - pause has no effect in IDLE or DONE.
- Not defined: the pause input is ignored and the countdown never freezes.

Test Plan:
1. CLK_HZ=10, GAME_SECONDS=3; reset then a 1-cycle startGame -> timer_running=1 next edge with secs_left=3. sec_tick fires at +10, +20, +30 cycles with secs_left=2, 1, 0. timer_expired=1 only at +30. game_over=1 from +30 onward.
2. Same setup, WARN_SECONDS=2 -> time_warning=0 while secs_left=3, =1 while secs_left is 2 or 1, =0 once secs_left=0 (DONE).
3. Reset asserted while secs_left=2 -> next cycle state IDLE with secs_left=3 and all flags 0. No timer_expired pulse for the following 50 cycles.
4. startGame pulsed while RUNNING -> count unaffected. startGame in DONE -> game_over=0 and secs_left=3 next edge, and the countdown repeats.
5. GAME_SECONDS=30, CLK_HZ=4 -> tens/ones read 3/0, then 2/9 after the first tick. After 20 ticks they read 1/0, then 0/9. The invariant holds every cycle.
6. GAME_TIMER_PAUSE_EN defined, pause=1 for 25 cycles mid-second -> expiry is delayed by exactly 25 cycles. Without the macro the same stimulus gives the unpaused expiry cycle.

Source files
------------

// File: rtl/game_countdown_timer.sv
// rtl/game_countdown_timer.sv - round countdown timer with 1 Hz prescaler and BCD outputs
//
// Purpose: divides clkIn down to a seconds tick, counts GAME_SECONDS down to 0,
// and produces the game FSM's timer_expired pulse plus display and LED signals.
// Optional feature macro: GAME_TIMER_PAUSE_EN (pause input freezes the countdown).
//
// Ports:
//   clkIn         in   system clock
//   reset         in   synchronous active-high reset
//   startGame     in   start/restart request (ignored while running)
//   pause         in   freeze countdown (only with GAME_TIMER_PAUSE_EN)
//   timer_running out  high while counting down
//   sec_tick      out  one-cycle pulse per elapsed second
//   timer_expired out  one-cycle pulse when the count reaches 0
//   game_over     out  high from expiry until next start or reset
//   secs_left     out  seconds remaining, binary
//   secs_tens     out  BCD tens digit of secs_left
//   secs_ones     out  BCD ones digit of secs_left
//   time_warning  out  high while running with 0 < secs_left <= WARN_SECONDS
module game_countdown_timer #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int GAME_SECONDS = 30,
  parameter int WARN_SECONDS = 5
) (
  input  logic       clkIn,
  input  logic       reset,
  input  logic       startGame,
  input  logic       pause,
  output logic       timer_running,
  output logic       sec_tick,
  output logic       timer_expired,
  output logic       game_over,
  output logic [6:0] secs_left,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       time_warning
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX    = PW'(CLK_HZ - 1);
  localparam logic [6:0]    GAME7      = 7'(GAME_SECONDS);
  localparam logic [6:0]    WARN7      = 7'(WARN_SECONDS);
  localparam logic [3:0]    GAME_TENS  = 4'(GAME_SECONDS / 10);
  localparam logic [3:0]    GAME_ONES  = 4'(GAME_SECONDS % 10);
  // Warning level right after a (re)start, when secs_left == GAME_SECONDS.
  localparam logic          START_WARN = (GAME_SECONDS <= WARN_SECONDS);

  typedef enum logic [1:0] {IDLE, RUNNING, DONE} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          hold;
  logic          wrap;
  logic [6:0]    secs_dec;

`ifdef GAME_TIMER_PAUSE_EN
  assign hold = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold = 1'b0;
`endif

  assign wrap     = (prescaler == PRE_MAX);
  assign secs_dec = secs_left - 7'd1;

  always_ff @(posedge clkIn) begin
    if (reset) begin
      state         <= IDLE;
      prescaler     <= '0;
      secs_left     <= GAME7;
      secs_tens     <= GAME_TENS;
      secs_ones     <= GAME_ONES;
      timer_running <= 1'b0;
      sec_tick      <= 1'b0;
      timer_expired <= 1'b0;
      game_over     <= 1'b0;
      time_warning  <= 1'b0;
    end else begin
      sec_tick      <= 1'b0;
      timer_expired <= 1'b0;
      case (state)
        RUNNING: begin
          // While paused every register simply holds, so time_warning keeps its value.
          if (!hold) begin
            if (wrap) begin
              prescaler <= '0;
              sec_tick  <= 1'b1;
              if (secs_left == 7'd1) begin
                state         <= DONE;
                secs_left     <= 7'd0;
                secs_tens     <= 4'd0;
                secs_ones     <= 4'd0;
                timer_expired <= 1'b1;
                timer_running <= 1'b0;
                game_over     <= 1'b1;
                time_warning  <= 1'b0;
              end else begin
                secs_left <= secs_dec;
                if (secs_ones == 4'd0) begin
                  secs_ones <= 4'd9;
                  secs_tens <= secs_tens - 4'd1;
                end else begin
                  secs_ones <= secs_ones - 4'd1;
                end
                // secs_dec is at least 1 here, so only the upper bound matters.
                time_warning <= (secs_dec <= WARN7);
              end
            end else begin
              prescaler <= prescaler + PW'(1);
            end
          end
        end
        default: begin
          // IDLE and DONE restart identically.
          if (startGame) begin
            state         <= RUNNING;
            prescaler     <= '0;
            secs_left     <= GAME7;
            secs_tens     <= GAME_TENS;
            secs_ones     <= GAME_ONES;
            timer_running <= 1'b1;
            game_over     <= 1'b0;
            time_warning  <= START_WARN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_countdown_timer.sv
// tb/tb_game_countdown_timer.sv - self-checking bench for game_countdown_timer
module tb_game_countdown_timer;

`ifdef GAME_TIMER_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] start = 2'b00;
  logic [1:0] pz = 2'b00;

  logic       run_a, tick_a, exp_a, over_a, warn_a;
  logic [6:0] secs_a;
  logic [3:0] tens_a, ones_a;
  logic       run_b, tick_b, exp_b, over_b, warn_b;
  logic [6:0] secs_b;
  logic [3:0] tens_b, ones_b;

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  int m_mode [2] = '{0, 0};
  int m_act  [2] = '{0, 0};
  bit m_tick [2] = '{0, 0};
  bit m_exp  [2] = '{0, 0};

  always #5 clk = ~clk;

  game_countdown_timer #(.CLK_HZ(10), .GAME_SECONDS(3), .WARN_SECONDS(2)) dut_a (
    .clkIn(clk), .reset(rst[0]), .startGame(start[0]), .pause(pz[0]),
    .timer_running(run_a), .sec_tick(tick_a), .timer_expired(exp_a), .game_over(over_a),
    .secs_left(secs_a), .secs_tens(tens_a), .secs_ones(ones_a), .time_warning(warn_a)
  );

  game_countdown_timer #(.CLK_HZ(4), .GAME_SECONDS(30), .WARN_SECONDS(5)) dut_b (
    .clkIn(clk), .reset(rst[1]), .startGame(start[1]), .pause(pz[1]),
    .timer_running(run_b), .sec_tick(tick_b), .timer_expired(exp_b), .game_over(over_b),
    .secs_left(secs_b), .secs_tens(tens_b), .secs_ones(ones_b), .time_warning(warn_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int p_hz(input int i);   return (i == 0) ? 10 : 4;  endfunction
  function automatic int p_game(input int i); return (i == 0) ? 3 : 30;  endfunction
  function automatic int p_warn(input int i); return (i == 0) ? 2 : 5;   endfunction

  // Model: mode 0=idle 1=running 2=done; m_act counts un-paused cycles since start.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int md = m_mode[i];
      automatic int ac = m_act[i];
      automatic bit tk = 1'b0;
      automatic bit ex = 1'b0;
      if (rst[i]) begin
        md = 0; ac = 0;
      end else if (md != 1) begin
        if (start[i]) begin md = 1; ac = 0; end
      end else if (!(PAUSE_EN && pz[i])) begin
        ac = ac + 1;
        if (ac % p_hz(i) == 0) tk = 1'b1;
        if (ac == p_game(i) * p_hz(i)) begin ex = 1'b1; md = 2; end
      end
      m_mode[i] <= md;
      m_act[i]  <= ac;
      m_tick[i] <= tk;
      m_exp[i]  <= ex;
    end
  end

  // {running, tick, expired, over, secs[6:0], tens[3:0], ones[3:0], warn}
  function automatic logic [19:0] model_vec(input int i);
    int secs;
    bit running;
    running = (m_mode[i] == 1);
    if (m_mode[i] == 0)      secs = p_game(i);
    else if (m_mode[i] == 2) secs = 0;
    else                     secs = p_game(i) - m_act[i] / p_hz(i);
    return {running, m_tick[i], m_exp[i], (m_mode[i] == 2), 7'(secs), 4'(secs / 10),
            4'(secs % 10), (running && secs > 0 && secs <= p_warn(i))};
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      check("outs_a", {run_a, tick_a, exp_a, over_a, secs_a, tens_a, ones_a, warn_a}, model_vec(0));
      check("outs_b", {run_b, tick_b, exp_b, over_b, secs_b, tens_b, ones_b, warn_b}, model_vec(1));
      check("bcd_inv_a", 32'(tens_a) * 10 + 32'(ones_a), 32'(secs_a));
      check("bcd_inv_b", 32'(tens_b) * 10 + 32'(ones_b), 32'(secs_b));
    end
  end

  initial begin
    int exp_k;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    check("rst_secs_a", secs_a, 3);
    check("rst_flags_a", {run_a, tick_a, exp_a, over_a, warn_a}, 0);
    check("rst_bcd_b", {tens_b, ones_b}, 8'h30);

    // Reset and start together: reset wins.
    start[0] = 1'b1;
    @(negedge clk);
    check("rst_start_idle", run_a, 0);
    start[0] = 1'b0;
    rst = 2'b00;

    // Full countdown on A with a stray start while running.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("start_running", run_a, 1);
    check("start_secs", secs_a, 3);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k == 9)  check("pre_tick_k9", {tick_a, secs_a, warn_a}, {1'b0, 7'd3, 1'b0});
      if (k == 10) check("tick_k10", {tick_a, secs_a, warn_a}, {1'b1, 7'd2, 1'b1});
      if (k == 20) check("tick_k20", {tick_a, secs_a, warn_a}, {1'b1, 7'd1, 1'b1});
      if (k == 29) check("no_exp_k29", exp_a, 0);
      if (k == 30) check("expire_k30", {tick_a, exp_a, over_a, run_a, secs_a, warn_a},
                         {1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0});
      if (k == 31) check("after_exp_k31", {exp_a, over_a}, 2'b01);
      start[0] = (k == 15);
    end

    // Restart from DONE.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("restart_done", {over_a, run_a, secs_a}, {1'b0, 1'b1, 7'd3});

    // Reset while secs_left == 2.
    repeat (12) @(negedge clk);
    check("pre_rst_secs", secs_a, 2);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("midrun_rst", {run_a, tick_a, exp_a, over_a, warn_a, secs_a}, {5'b0, 7'd3});
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (exp_a) check("no_exp_after_rst", exp_a, 0);
    end
    check("idle_after_50", run_a, 0);

    // Pause for 25 cycles mid-second.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    exp_k = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (exp_a && exp_k < 0) exp_k = k;
      pz[0] = (k >= 5 && k < 30);
    end
    check("pause_expiry_k", exp_k, PAUSE_EN ? 55 : 30);

    // Two-digit BCD on B.
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    check("b_start_bcd", {tens_b, ones_b}, 8'h30);
    for (int k = 1; k <= 125; k++) begin
      @(negedge clk);
      if (k == 4)   check("b_bcd_29", {tens_b, ones_b}, 8'h29);
      if (k == 80)  check("b_bcd_10", {tens_b, ones_b, secs_b}, {8'h10, 7'd10});
      if (k == 84)  check("b_bcd_09", {tens_b, ones_b, secs_b}, {8'h09, 7'd9});
      if (k == 100) check("b_warn_5", {warn_b, secs_b}, {1'b1, 7'd5});
      if (k == 120) check("b_expire", {exp_b, over_b, secs_b}, {1'b1, 1'b1, 7'd0});
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
